// File: rtl/q_setpoint_sequencer_if.sv
// Setpoint push bus: valid/ready handshake carrying one (charge, dwell) pair per beat.
interface q_setpoint_sequencer_if #(
  parameter int BUS_WIDTH   = 10,
  parameter int DWELL_WIDTH = 8
);
  logic                   sp_valid;
  logic                   sp_ready;
  logic [BUS_WIDTH-1:0]   sp_q;
  logic [DWELL_WIDTH-1:0] sp_dwell;

  modport master (output sp_valid, output sp_q, output sp_dwell, input sp_ready);
  modport slave  (input sp_valid, input sp_q, input sp_dwell, output sp_ready);
endinterface

// File: rtl/q_setpoint_sequencer.sv
// Feeds queued charge setpoints into the Q-control loop, waits for convergence,
// holds each for its dwell time and traps settle timeouts / instability in FAULT.
module q_setpoint_sequencer #(
  parameter int BUS_WIDTH   = 10,
  parameter int DEPTH       = 4,
  parameter int DWELL_WIDTH = 8,
  parameter int TIMEOUT     = 10000,
  parameter int TO_WIDTH    = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  q_setpoint_sequencer_if.slave      sp_if,
  input  logic                       run_i,
  input  logic                       abort_i,
  input  logic                       converged_i,
  input  logic                       unstable_i,
  output logic                       start_o,
  output logic                       enable_o,
  output logic [BUS_WIDTH-1:0]       q_desired_o,
  output logic                       busy_o,
  output logic                       sp_done_o,
  output logic                       seq_done_o,
  output logic                       timeout_err_o,
  output logic                       instb_err_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = BUS_WIDTH + DWELL_WIDTH;
  localparam logic [LW-1:0]          LVL_ZERO = LW'(0);
  localparam logic [LW-1:0]          LVL_FULL = LW'(DEPTH);
  localparam logic [TO_WIDTH-1:0]    TO_ZERO  = TO_WIDTH'(0);
  localparam logic [TO_WIDTH-1:0]    TO_BLANK = TO_WIDTH'(2);
  localparam logic [TO_WIDTH-1:0]    TO_LAST  = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [DWELL_WIDTH-1:0] DW_ZERO  = DWELL_WIDTH'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_DWELL  = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q;
  logic [DWELL_WIDTH-1:0] dwell_reg_q, dwell_cnt_q, dwell_cnt_d;
  logic [TO_WIDTH-1:0]    to_q, to_d;
  logic                   start_q, enable_q, busy_q, sp_done_q, seq_done_q;
  logic                   timeout_err_q, instb_err_q;
  logic [BUS_WIDTH-1:0]   q_desired_q;
  logic                   push_s, pop_s, complete_s, seq_s, timeout_s, instb_s, conv_s;
  logic [EW-1:0]          head_s;

  assign sp_if.sp_ready = !rst && (level_q != LVL_FULL);
  assign push_s         = sp_if.sp_valid && sp_if.sp_ready && !abort_i;
  assign head_s         = mem_q[rd_ptr_q];
  // The first two SETTLE cycles mask a stale converged flag from the previous setpoint.
  assign conv_s         = converged_i && (to_q >= TO_BLANK);

  // Next-state, pop request and event decode.
  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q;
    to_d        = (state_q == S_SETTLE) ? to_q + TO_WIDTH'(1) : TO_ZERO;
    pop_s       = 1'b0;
    complete_s  = 1'b0;
    seq_s       = 1'b0;
    timeout_s   = 1'b0;
    instb_s     = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_i && (level_q != LVL_ZERO)) begin
            pop_s   = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          if (unstable_i) begin
            instb_s = 1'b1;
            state_d = S_FAULT;
          end else begin
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (unstable_i) begin
            instb_s = 1'b1;
            state_d = S_FAULT;
          end else if (conv_s) begin
            dwell_cnt_d = dwell_reg_q;
            state_d     = S_DWELL;
          end else if (to_q == TO_LAST) begin
            timeout_s = 1'b1;
            state_d   = S_FAULT;
          end else begin
            state_d = S_SETTLE;
          end
        end
        S_DWELL: begin
          if (unstable_i) begin
            instb_s = 1'b1;
            state_d = S_FAULT;
          end else if (!converged_i) begin
            dwell_cnt_d = dwell_reg_q;
            state_d     = S_SETTLE;
          end else if (dwell_cnt_q == DW_ZERO) begin
            complete_s = 1'b1;
            if (run_i && (level_q != LVL_ZERO)) begin
              pop_s   = 1'b1;
              state_d = S_LOAD;
            end else begin
              seq_s   = (level_q == LVL_ZERO);
              state_d = S_IDLE;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
          end
        end
        S_FAULT: begin
          if (!run_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FAULT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Setpoint FIFO storage (no reset needed; occupancy guards every read).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {sp_if.sp_dwell, sp_if.sp_q};
    end
  end

  // FIFO pointers and occupancy; abort flushes everything including a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      level_q  <= LVL_ZERO;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_s && !pop_s)      level_q <= level_q + LW'(1);
      else if (pop_s && !push_s) level_q <= level_q - LW'(1);
    end
  end

  // Sequencer state, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dwell_reg_q   <= DW_ZERO;
      dwell_cnt_q   <= DW_ZERO;
      to_q          <= TO_ZERO;
      q_desired_q   <= BUS_WIDTH'(0);
      start_q       <= 1'b0;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
      sp_done_q     <= 1'b0;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      instb_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      to_q        <= to_d;
      if (pop_s) begin
        q_desired_q <= head_s[BUS_WIDTH-1:0];
        dwell_reg_q <= head_s[EW-1:BUS_WIDTH];
      end
      start_q       <= (state_d == S_SETTLE) || (state_d == S_DWELL);
      enable_q      <= (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_DWELL);
      busy_q        <= (state_d != S_IDLE) && (state_d != S_FAULT);
      sp_done_q     <= complete_s;
      seq_done_q    <= seq_s;
      timeout_err_q <= timeout_err_q | timeout_s;
      instb_err_q   <= instb_err_q | instb_s;
    end
  end

  assign start_o       = start_q;
  assign enable_o      = enable_q;
  assign q_desired_o   = q_desired_q;
  assign busy_o        = busy_q;
  assign sp_done_o     = sp_done_q;
  assign seq_done_o    = seq_done_q;
  assign timeout_err_o = timeout_err_q;
  assign instb_err_o   = instb_err_q;
  assign level_o       = level_q;
endmodule

// File: tb/tb_q_setpoint_sequencer.sv
// Directed bench for q_setpoint_sequencer: single setpoint, full FIFO, timeout,
// instability, convergence loss during dwell, abort and mid-run reset.
module tb_q_setpoint_sequencer;
  localparam int BW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst, run, abort, converged, unstable;
  logic start, enable, busy, sp_done, seq_done, timeout_err, instb_err;
  logic [BW-1:0] q_desired;
  logic [2:0]    level;
  int n_cmp = 0;
  int n_err = 0;
  int cnt, ndone, nseq, nload, done_at, nstart, gap_err, seq_last;
  logic [BW-1:0] loads [4];

  q_setpoint_sequencer_if #(.BUS_WIDTH(BW), .DWELL_WIDTH(DW)) sp_if ();

  q_setpoint_sequencer #(
    .BUS_WIDTH(BW), .DEPTH(4), .DWELL_WIDTH(DW), .TIMEOUT(50), .TO_WIDTH(14)
  ) dut (
    .clk(clk), .rst(rst), .sp_if(sp_if),
    .run_i(run), .abort_i(abort), .converged_i(converged), .unstable_i(unstable),
    .start_o(start), .enable_o(enable), .q_desired_o(q_desired), .busy_o(busy),
    .sp_done_o(sp_done), .seq_done_o(seq_done), .timeout_err_o(timeout_err),
    .instb_err_o(instb_err), .level_o(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [BW-1:0] q, input logic [DW-1:0] d);
    sp_if.sp_valid = 1'b1;
    sp_if.sp_q     = q;
    sp_if.sp_dwell = d;
    tick();
    sp_if.sp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; abort = 1'b0; converged = 1'b0; unstable = 1'b0;
    sp_if.sp_valid = 1'b0; sp_if.sp_q = '0; sp_if.sp_dwell = '0;
    tick(); tick();
    chk("rst_ready", 32'(sp_if.sp_ready), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_qdes", 32'(q_desired), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_errs", 32'({timeout_err, instb_err, busy, sp_done, seq_done}), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(sp_if.sp_ready), 32'd1);

    // Single setpoint q=120, dwell=5
    run = 1'b1;
    push(10'd120, 8'd5);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_idle_enable", 32'(enable), 32'd0);
    tick();
    chk("t1_qdes", 32'(q_desired), 32'd120);
    chk("t1_load_en", 32'(enable), 32'd1);
    chk("t1_load_start", 32'(start), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_popped", 32'(level), 32'd0);
    tick();
    chk("t1_start_rise", 32'(start), 32'd1);
    converged = 1'b1;
    ndone = 0; nseq = 0; done_at = 0; nstart = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (sp_done) begin ndone++; done_at = i; end
      if (seq_done) nseq++;
      if (start) nstart++;
    end
    chk("t1_ndone", 32'(ndone), 32'd1);
    chk("t1_done_at", 32'(done_at), 32'd9);
    chk("t1_nseq", 32'(nseq), 32'd1);
    chk("t1_start_cycles", 32'(nstart), 32'd8);
    chk("t1_end_en", 32'({start, enable, busy}), 32'd0);
    chk("t1_qhold", 32'(q_desired), 32'd120);
    converged = 1'b0;

    // Fill FIFO, overfill ignored, then issue in order with dwell=0
    run = 1'b0;
    push(10'd100, 8'd0);
    push(10'd200, 8'd0);
    push(10'd300, 8'd0);
    push(10'd400, 8'd0);
    chk("t2_full_level", 32'(level), 32'd4);
    chk("t2_full_ready", 32'(sp_if.sp_ready), 32'd0);
    push(10'd500, 8'd0);
    chk("t2_overfill", 32'(level), 32'd4);
    run = 1'b1; converged = 1'b1;
    nload = 0; ndone = 0; nseq = 0; gap_err = 0; seq_last = 0; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sp_done) ndone++;
      if (seq_done) begin
        nseq++;
        if (sp_done && ndone == 4) seq_last = 1;
      end
      if (enable && !start) begin
        if (nload < 4) loads[nload] = q_desired;
        nload++;
        cnt = 1;
      end
      if (cnt == 1 && ndone < 4 && !enable) gap_err++;
    end
    chk("t2_nload", 32'(nload), 32'd4);
    chk("t2_order0", 32'(loads[0]), 32'd100);
    chk("t2_order1", 32'(loads[1]), 32'd200);
    chk("t2_order2", 32'(loads[2]), 32'd300);
    chk("t2_order3", 32'(loads[3]), 32'd400);
    chk("t2_ndone", 32'(ndone), 32'd4);
    chk("t2_nseq", 32'(nseq), 32'd1);
    chk("t2_seq_with_last", 32'(seq_last), 32'd1);
    chk("t2_enable_gap", 32'(gap_err), 32'd0);
    chk("t2_level_end", 32'(level), 32'd0);
    converged = 1'b0;

    // Settle timeout, FAULT holds while run=1
    push(10'd7, 8'd0);
    tick();
    chk("t3_load", 32'(enable), 32'd1);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (start) cnt++;
      else break;
    end
    chk("t3_settle_cycles", 32'(cnt), 32'd50);
    chk("t3_timeout_err", 32'(timeout_err), 32'd1);
    chk("t3_fault_en", 32'(enable), 32'd0);
    chk("t3_instb_clear", 32'(instb_err), 32'd0);
    push(10'd9, 8'd0);
    tick(); tick();
    chk("t3_fault_hold_level", 32'(level), 32'd1);
    chk("t3_fault_hold_en", 32'(enable), 32'd0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    chk("t3_left_fault", 32'({enable, start}), 32'b10);
    chk("t3_qdes9", 32'(q_desired), 32'd9);
    chk("t3_sticky", 32'(timeout_err), 32'd1);

    // Instability together with convergence in SETTLE
    tick(); tick(); tick();
    converged = 1'b1; unstable = 1'b1;
    tick();
    chk("t4_instb", 32'(instb_err), 32'd1);
    chk("t4_fault_en", 32'({start, enable}), 32'd0);
    chk("t4_no_done", 32'(sp_done), 32'd0);
    converged = 1'b0; unstable = 1'b0;
    tick();
    chk("t4_no_done2", 32'(sp_done), 32'd0);
    run = 1'b0;
    tick();
    run = 1'b1;

    // Convergence lost at dwell count 2 of 5
    converged = 1'b1;
    push(10'd55, 8'd5);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_in_dwell", 32'({start, sp_done}), 32'b10);
    converged = 1'b0;
    tick();
    chk("t5_resettle", 32'({start, enable, sp_done}), 32'b110);
    converged = 1'b1;
    done_at = 0; nseq = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (sp_done && done_at == 0) done_at = i;
      if (seq_done) nseq++;
    end
    chk("t5_done_at", 32'(done_at), 32'd9);
    chk("t5_nseq", 32'(nseq), 32'd1);

    // Abort in DWELL with level=3 and a simultaneous push
    push(10'd11, 8'd20);
    sp_if.sp_valid = 1'b1;
    sp_if.sp_q = 10'd12; tick();
    sp_if.sp_q = 10'd13; tick();
    sp_if.sp_q = 10'd14; tick();
    sp_if.sp_valid = 1'b0;
    tick(); tick();
    chk("t6_level3", 32'(level), 32'd3);
    chk("t6_dwell_start", 32'(start), 32'd1);
    abort = 1'b1; sp_if.sp_valid = 1'b1; sp_if.sp_q = 10'd99;
    tick();
    abort = 1'b0; sp_if.sp_valid = 1'b0;
    chk("t6_flush", 32'(level), 32'd0);
    chk("t6_outs", 32'({start, enable, busy, sp_done, seq_done}), 32'd0);
    chk("t6_errs_kept", 32'({timeout_err, instb_err}), 32'b11);
    tick();
    chk("t6_push_dropped", 32'(level), 32'd0);
    chk("t6_stay_idle", 32'({enable, sp_done}), 32'd0);

    // Reset in the middle of SETTLE
    converged = 1'b0;
    push(10'd77, 8'd3);
    tick(); tick(); tick();
    chk("t7_pre_start", 32'(start), 32'd1);
    rst = 1'b1;
    tick();
    chk("t7_rst_outs", 32'({start, enable, busy, sp_done, seq_done}), 32'd0);
    chk("t7_rst_errs", 32'({timeout_err, instb_err}), 32'd0);
    chk("t7_rst_qdes", 32'(q_desired), 32'd0);
    chk("t7_rst_level", 32'(level), 32'd0);
    chk("t7_rst_ready", 32'(sp_if.sp_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("t7_post_ready", 32'(sp_if.sp_ready), 32'd1);
    chk("t7_post_idle", 32'({enable, level}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
